// File: rtl/csr_reg_if.sv
// ---------------------------------------------------------------------------
// csr_reg_if
// Bundles the CSR access ports of csr_reg: the EX-stage write port, the ID
// read port, the CLINT write/read port, the retire strobe, and the mirrored
// mtvec/mepc/mstatus registers exported to the CLINT.
//   master : drives writes, read addresses and inst_retire; sees read data
//   slave  : the CSR register file itself
// Addresses are 32 bits wide but only bits [11:0] select a CSR.
// ---------------------------------------------------------------------------
interface csr_reg_if;
    logic        ex_wen;
    logic [31:0] ex_waddr;
    logic [31:0] ex_wdata;
    logic [31:0] id_raddr;
    logic [31:0] id_rdata;
    logic        clint_wen;
    logic [31:0] clint_waddr;
    logic [31:0] clint_wdata;
    logic [31:0] clint_raddr;
    logic [31:0] clint_rdata;
    logic        inst_retire;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic [31:0] csr_mstatus;

    modport master (
        output ex_wen, ex_waddr, ex_wdata, id_raddr,
        output clint_wen, clint_waddr, clint_wdata, clint_raddr, inst_retire,
        input  id_rdata, clint_rdata, csr_mtvec, csr_mepc, csr_mstatus
    );

    modport slave (
        input  ex_wen, ex_waddr, ex_wdata, id_raddr,
        input  clint_wen, clint_waddr, clint_wdata, clint_raddr, inst_retire,
        output id_rdata, clint_rdata, csr_mtvec, csr_mepc, csr_mstatus
    );
endinterface

// File: rtl/csr_reg.sv
// ---------------------------------------------------------------------------
// csr_reg
// Machine-mode CSR register file. Holds mstatus, mie, mtvec, mscratch, mepc,
// mcause, the 64-bit mcycle/minstret counters and read-only mhartid.
// Two write ports (EX, CLINT) commit at posedge; CLINT wins on a same-address
// collision. Two combinational read ports: the ID port bypasses an in-flight
// EX write to the same writable CSR, the CLINT port reads committed state.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   bus    : csr_reg_if.slave (write/read ports, retire strobe, exported CSRs)
// ---------------------------------------------------------------------------
module csr_reg #(
    parameter logic [31:0] HART_ID   = 32'd0,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input logic      clk_i,
    input logic      rst_i,
    csr_reg_if.slave bus
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTR   = 12'hB02;
    localparam logic [11:0] A_MINSTRH  = 12'hB82;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;
    localparam logic [11:0] A_INSTR    = 12'hC02;
    localparam logic [11:0] A_INSTRH   = 12'hC82;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    // mstatus: only MIE (3) and MPIE (7) are writable; MPP (12:11) is fixed M-mode.
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;

    typedef struct packed {
        logic        en;
        logic [31:0] data;
    } wr_t;

    logic [11:0] ex_a, cl_a, id_a, cr_a;
    assign ex_a = bus.ex_waddr[11:0];
    assign cl_a = bus.clint_waddr[11:0];
    assign id_a = bus.id_raddr[11:0];
    assign cr_a = bus.clint_raddr[11:0];

    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.ex_waddr[31:12], bus.clint_waddr[31:12],
                              bus.id_raddr[31:12], bus.clint_raddr[31:12]};

    logic [31:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [63:0] mcycle_q, minstret_q;

    // Per-CSR resolved write: CLINT has priority over EX on the same address.
    function automatic wr_t resolve(input logic [11:0] a,
                                    input logic ew, input logic [11:0] ea, input logic [31:0] ed,
                                    input logic cw, input logic [11:0] ca, input logic [31:0] cd);
        wr_t w;
        w.en   = 1'b0;
        w.data = '0;
        if (cw && ca == a) begin
            w.en   = 1'b1;
            w.data = cd;
        end else if (ew && ea == a) begin
            w.en   = 1'b1;
            w.data = ed;
        end
        return w;
    endfunction

    // WARL legalisation of a write value; counter halves and full-width CSRs pass through.
    function automatic logic [31:0] legalize(input logic [11:0] a, input logic [31:0] d);
        case (a)
            A_MSTATUS:      return (d & MSTATUS_WMASK) | MSTATUS_FIXED;
            A_MIE:          return d & MIE_WMASK;
            A_MTVEC, A_MEPC: return {d[31:2], 2'b00};
            default:        return d;
        endcase
    endfunction

    function automatic logic is_writable(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
            A_MCYCLE, A_MCYCLEH, A_MINSTR, A_MINSTRH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] read_csr(input logic [11:0] a);
        case (a)
            A_MSTATUS:            return mstatus_q;
            A_MIE:                return mie_q;
            A_MTVEC:              return mtvec_q;
            A_MSCRATCH:           return mscratch_q;
            A_MEPC:               return mepc_q;
            A_MCAUSE:             return mcause_q;
            A_MCYCLE, A_CYCLE:    return mcycle_q[31:0];
            A_MCYCLEH, A_CYCLEH:  return mcycle_q[63:32];
            A_MINSTR, A_INSTR:    return minstret_q[31:0];
            A_MINSTRH, A_INSTRH:  return minstret_q[63:32];
            A_MHARTID:            return HART_ID;
            default:              return 32'h0;
        endcase
    endfunction

    wr_t w_mstatus, w_mie, w_mtvec, w_mscratch, w_mepc, w_mcause;
    wr_t w_cyc_lo, w_cyc_hi, w_ins_lo, w_ins_hi;

    assign w_mstatus  = resolve(A_MSTATUS,  bus.ex_wen, ex_a, bus.ex_wdata, bus.clint_wen, cl_a, bus.clint_wdata);
    assign w_mie      = resolve(A_MIE,      bus.ex_wen, ex_a, bus.ex_wdata, bus.clint_wen, cl_a, bus.clint_wdata);
    assign w_mtvec    = resolve(A_MTVEC,    bus.ex_wen, ex_a, bus.ex_wdata, bus.clint_wen, cl_a, bus.clint_wdata);
    assign w_mscratch = resolve(A_MSCRATCH, bus.ex_wen, ex_a, bus.ex_wdata, bus.clint_wen, cl_a, bus.clint_wdata);
    assign w_mepc     = resolve(A_MEPC,     bus.ex_wen, ex_a, bus.ex_wdata, bus.clint_wen, cl_a, bus.clint_wdata);
    assign w_mcause   = resolve(A_MCAUSE,   bus.ex_wen, ex_a, bus.ex_wdata, bus.clint_wen, cl_a, bus.clint_wdata);
    assign w_cyc_lo   = resolve(A_MCYCLE,   bus.ex_wen, ex_a, bus.ex_wdata, bus.clint_wen, cl_a, bus.clint_wdata);
    assign w_cyc_hi   = resolve(A_MCYCLEH,  bus.ex_wen, ex_a, bus.ex_wdata, bus.clint_wen, cl_a, bus.clint_wdata);
    assign w_ins_lo   = resolve(A_MINSTR,   bus.ex_wen, ex_a, bus.ex_wdata, bus.clint_wen, cl_a, bus.clint_wdata);
    assign w_ins_hi   = resolve(A_MINSTRH,  bus.ex_wen, ex_a, bus.ex_wdata, bus.clint_wen, cl_a, bus.clint_wdata);

    // NOTE: reset is sampled on the clock edge only, so every register here
    // (including the 64-bit counters) is covered by the same synchronous branch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, which the counter carry and bypass logic rely on.
            mstatus_q  <= MSTATUS_FIXED;
            mie_q      <= 32'h0;
            mtvec_q    <= {MTVEC_RST[31:2], 2'b00};
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
        end else begin
            if (w_mstatus.en)  mstatus_q  <= legalize(A_MSTATUS, w_mstatus.data);
            if (w_mie.en)      mie_q      <= legalize(A_MIE, w_mie.data);
            if (w_mtvec.en)    mtvec_q    <= legalize(A_MTVEC, w_mtvec.data);
            if (w_mscratch.en) mscratch_q <= w_mscratch.data;
            if (w_mepc.en)     mepc_q     <= legalize(A_MEPC, w_mepc.data);
            if (w_mcause.en)   mcause_q   <= w_mcause.data;

            // A write to either half freezes the whole counter for that cycle.
            if (w_cyc_lo.en || w_cyc_hi.en) begin
                if (w_cyc_lo.en) mcycle_q[31:0]  <= w_cyc_lo.data;
                if (w_cyc_hi.en) mcycle_q[63:32] <= w_cyc_hi.data;
            end else begin
                mcycle_q <= mcycle_q + 64'd1;
            end

            if (w_ins_lo.en || w_ins_hi.en) begin
                if (w_ins_lo.en) minstret_q[31:0]  <= w_ins_lo.data;
                if (w_ins_hi.en) minstret_q[63:32] <= w_ins_hi.data;
            end else if (bus.inst_retire) begin
                minstret_q <= minstret_q + 64'd1;
            end
        end
    end

    logic [31:0] id_rdata_c, clint_rdata_c;

    always_comb begin
        id_rdata_c = read_csr(id_a);
        if (bus.ex_wen && ex_a == id_a && is_writable(id_a)) begin
            if (bus.clint_wen && cl_a == id_a) id_rdata_c = legalize(id_a, bus.clint_wdata);
            else                               id_rdata_c = legalize(id_a, bus.ex_wdata);
        end
    end

    always_comb begin
        clint_rdata_c = read_csr(cr_a);
    end

    assign bus.id_rdata    = id_rdata_c;
    assign bus.clint_rdata = clint_rdata_c;
    assign bus.csr_mtvec   = mtvec_q;
    assign bus.csr_mepc    = mepc_q;
    assign bus.csr_mstatus = mstatus_q;
endmodule

// File: tb/tb_csr_reg.sv
// ---------------------------------------------------------------------------
// tb_csr_reg
// Self-checking bench for csr_reg: directed sequences, a vector table and a
// randomized phase, all compared against a CSR map model kept in this file.
// ---------------------------------------------------------------------------
module tb_csr_reg;
    localparam logic [31:0] HART_ID   = 32'h0000_0005;
    localparam logic [31:0] MTVEC_RST = 32'h8000_0103;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    csr_reg_if bus ();

    csr_reg #(.HART_ID(HART_ID), .MTVEC_RST(MTVEC_RST)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model: address-keyed CSR map ----------------
    logic [31:0] regs [logic [11:0]];
    logic [63:0] m_cycle, m_instret;
    bit          valid = 0;

    function automatic logic [31:0] wmask(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_0088;
            12'h304: return 32'h0000_0888;
            12'h305, 12'h341: return 32'hFFFF_FFFC;
            12'h340, 12'h342: return 32'hFFFF_FFFF;
            12'hB00, 12'hB80, 12'hB02, 12'hB82: return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] legal(input logic [11:0] a, input logic [31:0] d);
        return (d & wmask(a)) | ((a == 12'h300) ? 32'h0000_1800 : 32'h0);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'hB00, 12'hC00: return m_cycle[31:0];
            12'hB80, 12'hC80: return m_cycle[63:32];
            12'hB02, 12'hC02: return m_instret[31:0];
            12'hB82, 12'hC82: return m_instret[63:32];
            12'hF14:          return HART_ID;
            default:          return regs.exists(a) ? regs[a] : 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_id(input logic ew, input logic [11:0] ea, input logic [31:0] ed,
                                             input logic cw, input logic [11:0] ca, input logic [31:0] cd,
                                             input logic [11:0] ida);
        if (ew && ea == ida && wmask(ida) != 0)
            return (cw && ca == ida) ? legal(ida, cd) : legal(ida, ed);
        return m_read(ida);
    endfunction

    bit cyc_w, ins_w;

    task automatic apply_write(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'hB00: begin m_cycle[31:0]    = d; cyc_w = 1; end
            12'hB80: begin m_cycle[63:32]   = d; cyc_w = 1; end
            12'hB02: begin m_instret[31:0]  = d; ins_w = 1; end
            12'hB82: begin m_instret[63:32] = d; ins_w = 1; end
            default: if (wmask(a) != 0) regs[a] = legal(a, d);
        endcase
    endtask

    task automatic commit(input logic r, input logic ew, input logic [11:0] ea, input logic [31:0] ed,
                          input logic cw, input logic [11:0] ca, input logic [31:0] cd, input logic ret);
        if (r) begin
            regs.delete();
            regs[12'h300] = 32'h0000_1800;
            regs[12'h304] = 32'h0;
            regs[12'h305] = MTVEC_RST & ~32'h3;
            regs[12'h340] = 32'h0;
            regs[12'h341] = 32'h0;
            regs[12'h342] = 32'h0;
            m_cycle   = 64'h0;
            m_instret = 64'h0;
            valid     = 1;
        end else begin
            cyc_w = 0;
            ins_w = 0;
            if (ew && !(cw && ca == ea)) apply_write(ea, ed);
            if (cw) apply_write(ca, cd);
            if (!cyc_w) m_cycle = m_cycle + 64'd1;
            if (!ins_w && ret) m_instret = m_instret + 64'd1;
        end
    endtask

    // ---------------- one clock of stimulus ----------------
    logic [31:0] s_id, s_clint;

    task automatic step(input logic r, input logic ew, input logic [11:0] ea, input logic [31:0] ed,
                        input logic cw, input logic [11:0] ca, input logic [31:0] cd,
                        input logic [11:0] ida, input logic [11:0] cra, input logic ret);
        @(negedge clk);
        rst             = r;
        bus.ex_wen      = ew;
        bus.ex_waddr    = {20'($urandom()), ea};
        bus.ex_wdata    = ed;
        bus.clint_wen   = cw;
        bus.clint_waddr = {20'($urandom()), ca};
        bus.clint_wdata = cd;
        bus.id_raddr    = {20'($urandom()), ida};
        bus.clint_raddr = {20'($urandom()), cra};
        bus.inst_retire = ret;
        #1;
        s_id    = bus.id_rdata;
        s_clint = bus.clint_rdata;
        if (valid && !r) begin
            check("id_rdata_model", s_id, model_id(ew, ea, ed, cw, ca, cd, ida));
            check("clint_rdata_model", s_clint, m_read(cra));
        end
        @(posedge clk);
        commit(r, ew, ea, ed, cw, ca, cd, ret);
        #1;
        if (valid) begin
            check("csr_mtvec_model",   bus.csr_mtvec,   regs[12'h305]);
            check("csr_mepc_model",    bus.csr_mepc,    regs[12'h341]);
            check("csr_mstatus_model", bus.csr_mstatus, regs[12'h300]);
        end
    endtask

    task automatic idle(input logic [11:0] ida, input logic [11:0] cra, input logic ret);
        step(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 32'h0, ida, cra, ret);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        ex_wen;
        logic [11:0] ex_a;
        logic [31:0] ex_d;
        logic        cl_wen;
        logic [11:0] cl_a;
        logic [31:0] cl_d;
        logic [11:0] id_a;
        logic [31:0] exp_id;
        logic [11:0] rd_a;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    logic [11:0] pool [0:15] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                 12'hC02, 12'hC82, 12'hF14, 12'h7C0};

    initial begin
        bus.ex_wen = 0; bus.ex_waddr = 0; bus.ex_wdata = 0; bus.id_raddr = 0;
        bus.clint_wen = 0; bus.clint_waddr = 0; bus.clint_wdata = 0; bus.clint_raddr = 0;
        bus.inst_retire = 0;

        vecs[0] = '{1'b1, 12'h300, 32'hFFFF_FFFF, 1'b0, 12'h000, 32'h0,  12'h300, 32'h0000_1888, 12'h300, 32'h0000_1888};
        vecs[1] = '{1'b1, 12'h304, 32'hFFFF_FFFF, 1'b0, 12'h000, 32'h0,  12'h304, 32'h0000_0888, 12'h304, 32'h0000_0888};
        vecs[2] = '{1'b1, 12'h305, 32'hFFFF_FFFF, 1'b0, 12'h000, 32'h0,  12'h305, 32'hFFFF_FFFC, 12'h305, 32'hFFFF_FFFC};
        vecs[3] = '{1'b1, 12'hF14, 32'hFFFF_FFFF, 1'b0, 12'h000, 32'h0,  12'hF14, HART_ID,       12'hF14, HART_ID};
        vecs[4] = '{1'b1, 12'h340, 32'h1234_5678, 1'b0, 12'h000, 32'h0,  12'h340, 32'h1234_5678, 12'h340, 32'h1234_5678};
        vecs[5] = '{1'b1, 12'h341, 32'h0000_0010, 1'b1, 12'h341, 32'h20, 12'h341, 32'h0000_0020, 12'h341, 32'h0000_0020};
        vecs[6] = '{1'b1, 12'h340, 32'h0000_AAAA, 1'b1, 12'h341, 32'h44, 12'h340, 32'h0000_AAAA, 12'h341, 32'h0000_0044};
        vecs[7] = '{1'b1, 12'h7C0, 32'hDEAD_BEEF, 1'b0, 12'h000, 32'h0,  12'h340, 32'h0000_AAAA, 12'h7C0, 32'h0000_0000};
        vecs[8] = '{1'b1, 12'h341, 32'h0000_1003, 1'b0, 12'h000, 32'h0,  12'h341, 32'h0000_1000, 12'h341, 32'h0000_1000};
        vecs[9] = '{1'b0, 12'h000, 32'h0,         1'b1, 12'h342, 32'h55, 12'h342, 32'h8000_0007, 12'h342, 32'h0000_0055};

        // Reset: registered outputs take reset values, mcycle reads 0 then 1.
        step(1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 32'h0, 12'h0, 12'h0, 1'b0);
        check("rst_mstatus", bus.csr_mstatus, 32'h0000_1800);
        check("rst_mtvec",   bus.csr_mtvec,   32'h8000_0100);
        check("rst_mepc",    bus.csr_mepc,    32'h0);
        idle(12'hB80, 12'hB00, 1'b0);
        check("rst_mcycle_0", s_clint, 32'h0);
        check("rst_mcycleh_0", s_id, 32'h0);
        idle(12'hB02, 12'hB00, 1'b0);
        check("rst_mcycle_1", s_clint, 32'h1);
        check("rst_minstret_0", s_id, 32'h0);

        // CLINT trap entry over three cycles.
        step(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 12'h341, 32'h8000_0104, 12'h0, 12'h0, 1'b0);
        step(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 12'h300, 32'h0000_1880, 12'h0, 12'h0, 1'b0);
        step(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 12'h342, 32'h8000_0007, 12'h0, 12'h0, 1'b0);
        check("trap_mepc",    bus.csr_mepc,    32'h8000_0104);
        check("trap_mstatus", bus.csr_mstatus, 32'h0000_1880);
        idle(12'h0, 12'h342, 1'b0);
        check("trap_mcause", s_clint, 32'h8000_0007);

        // Table: masks, RO drop, bypass, collisions, unmapped.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, vecs[i].ex_wen, vecs[i].ex_a, vecs[i].ex_d, vecs[i].cl_wen, vecs[i].cl_a,
                 vecs[i].cl_d, vecs[i].id_a, 12'h0, 1'b0);
            check($sformatf("vec%0d_id", i), s_id, vecs[i].exp_id);
            idle(vecs[i].rd_a, vecs[i].rd_a, 1'b0);
            check($sformatf("vec%0d_rd", i), s_clint, vecs[i].exp_rd);
        end
        check("diff_addr_mepc", bus.csr_mepc, 32'h0000_1000);

        // mcycle wrap: both halves written in one cycle, then carry lo->hi.
        step(1'b0, 1'b1, 12'hB00, 32'hFFFF_FFFF, 1'b1, 12'hB80, 32'h0, 12'h0, 12'h0, 1'b0);
        idle(12'hB80, 12'hB00, 1'b0);
        check("wrap_cyc_hi_0", s_id, 32'h0);
        check("wrap_cyc_lo_0", s_clint, 32'hFFFF_FFFF);
        idle(12'hB80, 12'hB00, 1'b0);
        check("wrap_cyc_hi_1", s_id, 32'h1);
        check("wrap_cyc_lo_1", s_clint, 32'h0);

        // minstret full 64-bit wrap; the write beats the retire in its own cycle.
        step(1'b0, 1'b1, 12'hB02, 32'hFFFF_FFFF, 1'b1, 12'hB82, 32'hFFFF_FFFF, 12'h0, 12'h0, 1'b1);
        idle(12'hB82, 12'hB02, 1'b1);
        check("wrap_ins_hi_max", s_id, 32'hFFFF_FFFF);
        check("wrap_ins_lo_max", s_clint, 32'hFFFF_FFFF);
        idle(12'hC82, 12'hC02, 1'b0);
        check("wrap_ins_hi_0", s_id, 32'h0);
        check("wrap_ins_lo_0", s_clint, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [11:0] ea, ca, ida, cra;
            logic [31:0] ed, cd;
            ea  = pool[$urandom_range(0, 15)];
            ca  = ($urandom_range(0, 3) == 0) ? ea : pool[$urandom_range(0, 15)];
            ida = ($urandom_range(0, 1) == 0) ? ea : pool[$urandom_range(0, 15)];
            cra = pool[$urandom_range(0, 15)];
            ed  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
            cd  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), ea, ed,
                 ($urandom_range(0, 2) == 0), ca, cd, ida, cra, ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
